// File: rtl/io_fifo_device.sv
// rtl/io_fifo_device.sv - Circular FIFO device with DMA stream/register access and a GPIO request line
// Optional status register at offset DEPTH is enabled by defining IO_FIFO_DEVICE_STATUS_EN.
module io_fifo_device #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int BASE   = 192,
    parameter int THRESH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [8:0]                   index,
    input  logic                         IOWrite,
    input  logic                         Ack,
    input  logic [DATA_W-1:0]            DataIn,
    output logic [DATA_W-1:0]            DataOut,
    output logic                         GPIO,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [1:0]        state, state_n;
    logic [CW-1:0]     count_n;

    logic              cs, cs_act, in_range;
    logic [7:0]        off;
    logic [PW-1:0]     off_addr;
    logic              push_ok, pop_ok, push_drop, pop_drop;
    logic [DATA_W-1:0] cs_rdata;

    assign cs       = index[8];
    assign off      = index[7:0] - 8'(BASE);
    assign off_addr = off[PW-1:0];
    assign in_range = ({1'b0, off} < 9'(DEPTH));
    // Ack wins over chip select; CS only acts when no DMA cycle is in progress.
    assign cs_act   = cs & ~Ack;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = Ack &  IOWrite & ~full;
    assign pop_ok    = Ack & ~IOWrite & ~empty;
    assign push_drop = Ack &  IOWrite &  full;
    assign pop_drop  = Ack & ~IOWrite &  empty;
    assign count_n   = count + CW'(push_ok) - CW'(pop_ok);

`ifdef IO_FIFO_DEVICE_STATUS_EN
    logic              ovf_flag, udf_flag, is_stat;
    logic [DATA_W-1:0] status_word;

    assign is_stat = ({1'b0, off} == 9'(DEPTH));

    always_comb begin
        status_word = '0;
        status_word[CW+3:0] = {ovf_flag, udf_flag, full, empty, count};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else if (cs_act && IOWrite && is_stat) begin
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (push_drop) ovf_flag <= 1'b1;
            if (pop_drop)  udf_flag <= 1'b1;
        end
    end

    always_comb begin
        cs_rdata = '0;
        if (in_range)     cs_rdata = mem[off_addr];
        else if (is_stat) cs_rdata = status_word;
    end
`else
    logic unused_drop;
    assign unused_drop = push_drop ^ pop_drop;

    always_comb begin
        cs_rdata = '0;
        if (in_range) cs_rdata = mem[off_addr];
    end
`endif

    // Buffer storage is deliberately left out of reset; only bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_ok)
                mem[wr_ptr] <= DataIn;
            else if (cs_act && IOWrite && in_range)
                mem[off_addr] <= DataIn;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (count_n >= CW'(THRESH)) state_n = S_REQ;
            S_REQ: begin
                if (count_n == '0)  state_n = S_IDLE;
                else if (Ack)       state_n = S_XFER;
            end
            S_XFER: begin
                if (count_n == '0)  state_n = S_IDLE;
                else if (!Ack)      state_n = S_REQ;
            end
            default:                state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= S_IDLE;
            GPIO    <= 1'b0;
            DataOut <= '0;
        end else begin
            count <= count_n;
            state <= state_n;
            GPIO  <= (state_n != S_IDLE);
            if (push_ok)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (Ack && !IOWrite)
                DataOut <= pop_ok ? mem[rd_ptr] : '0;
            else if (cs_act && !IOWrite)
                DataOut <= cs_rdata;
        end
    end

endmodule

// File: tb/tb_io_fifo_device.sv
// tb/tb_io_fifo_device.sv - Table-driven directed bench for io_fifo_device (DEPTH=4, THRESH=1)
module tb_io_fifo_device;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  index;
    logic        IOWrite, Ack;
    logic [31:0] DataIn, DataOut;
    logic        GPIO, full, empty;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    io_fifo_device #(.DATA_W(32), .DEPTH(4), .BASE(192), .THRESH(1)) dut (
        .clk(clk), .rst(rst), .index(index), .IOWrite(IOWrite), .Ack(Ack),
        .DataIn(DataIn), .DataOut(DataOut), .GPIO(GPIO), .count(count),
        .full(full), .empty(empty)
    );

    typedef struct {
        logic        rst;
        logic [8:0]  idx;
        logic        wr;
        logic        ack;
        logic [31:0] din;
        logic [31:0] dout;
        logic        gpio;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
    } vec_t;

    vec_t vecs[$];

`ifdef IO_FIFO_DEVICE_STATUS_EN
    localparam logic [31:0] ST_OVF = 32'h54;
    localparam logic [31:0] ST_CLR = 32'h14;
`else
    localparam logic [31:0] ST_OVF = 32'h0;
    localparam logic [31:0] ST_CLR = 32'h0;
`endif

    localparam logic [8:0] NOCS = 9'h000;

    function automatic vec_t v(logic r, logic [8:0] i, logic w, logic a, logic [31:0] d,
                               logic [31:0] eo, logic eg, logic [2:0] ec, logic ef, logic ee);
        vec_t t;
        t.rst = r; t.idx = i; t.wr = w; t.ack = a; t.din = d;
        t.dout = eo; t.gpio = eg; t.cnt = ec; t.full = ef; t.empty = ee;
        return t;
    endfunction

    task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    initial begin
        //              rst idx     wr ack din       dout      gpio cnt full empty
        vecs.push_back(v(1, NOCS,   0, 0, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   1, 1, 32'h11,    0,        1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'h22,    0,        1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'h33,    0,        1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'h11,   1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'h22,   1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'h33,   0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   0, 0, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hA1,    0,        1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hA2,    0,        1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hA3,    0,        1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hA4,    0,        1,   4,  1,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hA5,    0,        1,   4,  1,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hA1,   1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hA2,   1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hB1,    32'hA2,   1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hB2,    32'hA2,   1,   4,  1,  0));
        vecs.push_back(v(0, NOCS,   0, 0, 0,         32'hA2,   1,   4,  1,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hA3,   1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hA4,   1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hB1,   1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   0, 1, 0,         32'hB2,   0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1C2, 1, 0, 32'hA5,    32'hB2,   0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1C2, 0, 0, 0,         32'hA5,   0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1FF, 0, 0, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1C0, 0, 0, 0,         32'hB2,   0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   0, 0, 0,         32'hB2,   0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1C3, 1, 1, 32'h77,    32'hB2,   1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'h88,    32'hB2,   1,   2,  0,  0));
        vecs.push_back(v(0, 9'h1C3, 0, 0, 0,         32'hB1,   1,   2,  0,  0));
        vecs.push_back(v(0, 9'h1C0, 0, 1, 0,         32'h77,   1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'h99,    32'h77,   1,   2,  0,  0));
        vecs.push_back(v(1, NOCS,   0, 1, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   0, 0, 0,         0,        0,   0,  0,  1));
        vecs.push_back(v(0, 9'h1C1, 0, 0, 0,         32'h77,   0,   0,  0,  1));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hC1,    32'h77,   1,   1,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hC2,    32'h77,   1,   2,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hC3,    32'h77,   1,   3,  0,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hC4,    32'h77,   1,   4,  1,  0));
        vecs.push_back(v(0, NOCS,   1, 1, 32'hC5,    32'h77,   1,   4,  1,  0));
        vecs.push_back(v(0, 9'h1C4, 0, 0, 0,         ST_OVF,   1,   4,  1,  0));
        vecs.push_back(v(0, 9'h1C4, 1, 0, 0,         ST_OVF,   1,   4,  1,  0));
        vecs.push_back(v(0, 9'h1C4, 0, 0, 0,         ST_CLR,   1,   4,  1,  0));

        rst = 1'b1; index = NOCS; IOWrite = 1'b0; Ack = 1'b0; DataIn = '0;
        @(negedge clk);
        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            index   = vecs[i].idx;
            IOWrite = vecs[i].wr;
            Ack     = vecs[i].ack;
            DataIn  = vecs[i].din;
            @(posedge clk);
            @(negedge clk);
            chk("dataout", i, DataOut, vecs[i].dout);
            chk("gpio",    i, 32'(GPIO),  32'(vecs[i].gpio));
            chk("count",   i, 32'(count), 32'(vecs[i].cnt));
            chk("full",    i, 32'(full),  32'(vecs[i].full));
            chk("empty",   i, 32'(empty), 32'(vecs[i].empty));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_fifo_device.md
IO_FIFO_DEVICE -- requirements
Module: io_fifo_device

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning buffer depth in words (2..256; power of two not required).
REQ-003 SHALL have parameter BASE, default 192, meaning index[7:0] value that maps to buffer word 0.
REQ-004 SHALL have parameter THRESH, default 1, meaning fill level (1..DEPTH) that raises a transfer request.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-007 SHALL have port index, input, 9, meaning bit 8 = chip select (CS); bits 7:0 = register address.
REQ-008 SHALL have port IOWrite, input, 1, meaning 1 = write into device, 0 = read from device.
REQ-009 SHALL have port Ack, input, 1, meaning DMA acknowledge; selects streaming (FIFO) access.
REQ-010 SHALL have port DataIn, input, DATA_W, meaning write data.
REQ-011 SHALL have port DataOut, output, DATA_W, meaning registered read data.
REQ-012 SHALL have port GPIO, output, 1, meaning registered DMA request / interrupt line.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1), meaning words currently held.
REQ-014 SHALL have ports full and empty, output, 1 each, meaning count==DEPTH and count==0 respectively.

Function
REQ-015 SHALL hold DEPTH words as a circular FIFO with wr_ptr, rd_ptr and count; each pointer wraps DEPTH-1 -> 0.
REQ-016 Stream push: Ack=1, IOWrite=1, not full -> buf[wr_ptr]<=DataIn, wr_ptr advances, count+1.
REQ-017 Stream pop: Ack=1, IOWrite=0, not empty -> DataOut<=buf[rd_ptr] on the same edge (1-cycle latency), rd_ptr advances, count-1.
REQ-018 Push when full SHALL be dropped (no state change); pop when empty SHALL drive DataOut<=0 and change nothing else.
REQ-019 Register access: CS=1, Ack=0, off=index[7:0]-BASE (8-bit) with off<DEPTH -> write buf[off]<=DataIn, or read DataOut<=buf[off]; pointers and count unchanged.
REQ-020 CS access with off>=DEPTH (except REQ-030) SHALL ignore writes and return DataOut<=0 on reads.
REQ-021 Ack=1 SHALL take priority over CS when both are asserted; CS is ignored that cycle.
REQ-022 With neither Ack nor CS asserted, DataOut SHALL hold its value.
REQ-023 Request FSM: states IDLE, REQ, XFER; GPIO=1 in REQ and XFER, 0 in IDLE; GPIO registered from next state.
REQ-024 Transitions: IDLE->REQ when count>=THRESH; REQ->XFER on Ack=1; XFER->REQ when Ack=0 and count>0; XFER->IDLE when the pop leaves count=0; REQ->IDLE if count becomes 0 via pop.
REQ-025 GPIO SHALL fall on the edge following the pop of the last word.

Reset
REQ-026 On rst=1 at a rising edge: wr_ptr, rd_ptr, count=0; empty=1, full=0; DataOut=0; GPIO=0; FSM=IDLE; flags of REQ-030 cleared.
REQ-027 Buffer contents SHALL NOT be cleared by reset.
REQ-028 rst SHALL override all simultaneous Ack/CS activity, including a burst in progress; the aborted burst is not resumed.

Configuration
REQ-029 Macro IO_FIFO_DEVICE_STATUS_EN SHALL enable a status register; without it offset DEPTH behaves per REQ-020.
REQ-030 With the macro: CS read at off=DEPTH returns {sticky overflow, sticky underflow, full, empty, count} zero-extended to DATA_W, LSB=count; overflow sets on REQ-018 push drop, underflow on REQ-018 empty pop; CS write at off=DEPTH clears both.

Verification
REQ-031 rst, then 3 stream pushes 0x11,0x22,0x33 (THRESH=1) -> GPIO=1 one edge after first push; count=3.
REQ-032 Then 3 stream pops -> DataOut 0x11,0x22,0x33 each one cycle after its pop; GPIO=0 one edge after third pop; empty=1.
REQ-033 DEPTH=4: push 5 words -> count=4, full=1, fifth dropped; pop 2, push 2 -> wrap verified, pop order preserved.
REQ-034 CS write index=9'h1C2 data 0xA5 -> CS read 9'h1C2 returns 0xA5; read 9'h1FF returns 0; count unchanged.
REQ-035 Ack=1 with CS=1 simultaneously -> only FIFO op occurs; rst mid-burst at count=2 -> count=0, GPIO=0, DataOut=0 next edge.
REQ-036 With IO_FIFO_DEVICE_STATUS_EN: overflow push then CS read off=DEPTH -> overflow bit 1; CS write off=DEPTH -> bit reads 0.
